// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_pkg
// Description : Shared RV32I data-path constants and types. The register
//               address type is reused by decode, write-back and the
//               register file.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32i_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

endpackage : rv32i_pkg
`default_nettype wire

// File: rtl/br_regfile_if.sv
`default_nettype none
// ============================================================================
// Module      : br_regfile_if
// Description : Register-file access bundle. Decode drives the read indices,
//               write-back drives the write index/data/enable, and the
//               register file returns the two read operands.
// Revision    : 1.0 - initial release
// ============================================================================
interface br_regfile_if #(
    parameter int XLEN = rv32i_pkg::XLEN
);
    import rv32i_pkg::reg_addr_t;

    reg_addr_t          a1;   // rs1 index
    reg_addr_t          a2;   // rs2 index
    reg_addr_t          a3;   // rd index
    logic [XLEN-1:0]    wd3;  // write-back data
    logic               we;   // write-back enable
    logic [XLEN-1:0]    rd1;  // rs1 operand
    logic [XLEN-1:0]    rd2;  // rs2 operand

    // Pipeline side: supplies indices and write-back, consumes operands
    modport master (
        output a1, a2, a3, wd3, we,
        input  rd1, rd2
    );

    // Register-file side
    modport slave (
        input  a1, a2, a3, wd3, we,
        output rd1, rd2
    );

endinterface : br_regfile_if
`default_nettype wire

// File: rtl/br_regfile.sv
`default_nettype none
// ============================================================================
// Module      : br_regfile
// Description : RV32I integer register file. Two combinational read ports,
//               one synchronous write port, x0 hardwired to zero. Storage is
//               a flop array so an asynchronous reset can clear every entry.
// Revision    : 1.0 - initial release
// ============================================================================
module br_regfile
    import rv32i_pkg::reg_addr_t;
    import rv32i_pkg::REG_ZERO;
#(
    parameter int XLEN = rv32i_pkg::XLEN,
    parameter int NREG = 32
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    br_regfile_if.slave     rf
);

    // Entry 0 has no storage at all; x0 cannot be corrupted by any write,
    // including one with an unknown enable or address.
    logic [XLEN-1:0] regs_q [1:NREG-1];
    logic [XLEN-1:0] regs_d [1:NREG-1];

    // Full read view with a constant zero in slot 0
    logic [XLEN-1:0] w_rdata [0:NREG-1];

    // Write decode: only the addressed entry (never x0) takes wd3
    always_comb begin
        regs_d = regs_q;
        for (int i = 1; i < NREG; i++) begin
            if (rf.we && (rf.a3 == reg_addr_t'(i))) begin
                regs_d[i] = rf.wd3;
            end
        end
    end

    // Storage: asynchronous clear, rising-edge commit once reset is released
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read view: slot 0 is tied to zero, the rest mirror the flops
    always_comb begin
        w_rdata[0] = '0;
        for (int i = 1; i < NREG; i++) begin
            w_rdata[i] = regs_q[i];
        end
    end

    // Read ports with the x0 mask applied on the read side; no write bypass,
    // so a same-cycle read of a3 returns the pre-edge contents.
    assign rf.rd1 = (rf.a1 == REG_ZERO) ? '0 : w_rdata[rf.a1];
    assign rf.rd2 = (rf.a2 == REG_ZERO) ? '0 : w_rdata[rf.a2];

endmodule : br_regfile
`default_nettype wire

// File: tb/tb_br_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_br_regfile
// Description : Self-checking bench for br_regfile: directed scenarios plus
//               randomized traffic against an array-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_br_regfile;

    logic clk;
    logic rst_n;

    br_regfile_if #(.XLEN(32)) rf ();

    br_regfile #(.XLEN(32), .NREG(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rf    (rf.slave)
    );

    // Reference model: architectural register contents, x0 never written
    logic [31:0] model [32];

    int n_checks = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    task automatic drive(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3,
                         input logic [31:0] wd, input logic we);
        rf.a1  = a1;
        rf.a2  = a2;
        rf.a3  = a3;
        rf.wd3 = wd;
        rf.we  = we;
    endtask

    // Advance one rising edge; the model commits what the bench is driving
    task automatic tick();
        @(posedge clk);
        if (rst_n === 1'b1 && rf.we === 1'b1 && rf.a3 != 5'd0) model[rf.a3] = rf.wd3;
        #1;
    endtask

    // Compare both read ports against the model for the current addresses
    task automatic check_ports(input string tag);
        check({tag, "_rd1"}, rf.rd1, model[rf.a1]);
        check({tag, "_rd2"}, rf.rd2, model[rf.a2]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_clear();
        rst_n = 1'b0;
        drive(5'd0, 5'd0, 5'd0, 32'h0, 1'b0);

        // Reset then scan: every address reads zero while in reset
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) begin
            rf.a1 = 5'(2 * i);
            rf.a2 = 5'(2 * i + 1);
            #1;
            check("reset_scan_rd1", rf.rd1, 32'h0);
            check("reset_scan_rd2", rf.rd2, 32'h0);
        end
        #2 rst_n = 1'b1;
        tick();

        // Basic writes, including a discarded write to x0
        drive(5'd0, 5'd0, 5'd10, 32'h0000_0012, 1'b1); tick();
        drive(5'd0, 5'd0, 5'd5,  32'h0000_f00f, 1'b1); tick();
        drive(5'd0, 5'd0, 5'd21, 32'h0000_0abc, 1'b1); tick();
        drive(5'd0, 5'd0, 5'd0,  32'hffff_ffff, 1'b1); tick();
        drive(5'd0, 5'd0, 5'd0,  32'h0, 1'b0);         tick();
        for (int i = 0; i < 32; i++) begin
            logic [31:0] exp;
            exp = (i == 5)  ? 32'h0000_f00f :
                  (i == 10) ? 32'h0000_0012 :
                  (i == 21) ? 32'h0000_0abc : 32'h0;
            rf.a1 = 5'(i);
            rf.a2 = 5'(31 - i);
            #1;
            check("basic_scan_rd1", rf.rd1, exp);
            check_ports("basic_scan");
        end

        // Write enable low: x7 must not move
        drive(5'd7, 5'd7, 5'd7, 32'hdead_beef, 1'b0);
        repeat (3) tick();
        check("we_low_x7", rf.rd1, 32'h0);

        // Unknown enable aimed at x0 leaves x0 at zero
        drive(5'd0, 5'd0, 5'd0, 32'hffff_ffff, 1'bx);
        tick();
        rf.we = 1'b0;
        #1;
        check("x_we_x0", rf.rd1, 32'h0);

        // Read-during-write: old value before the edge, new value after
        drive(5'd12, 5'd12, 5'd12, 32'h1111_1111, 1'b1);
        #1;
        check("rdw1_before_rd1", rf.rd1, 32'h0);
        check("rdw1_before_rd2", rf.rd2, 32'h0);
        tick();
        check("rdw1_after_rd1", rf.rd1, 32'h1111_1111);
        check("rdw1_after_rd2", rf.rd2, 32'h1111_1111);
        rf.wd3 = 32'h2222_2222;
        #1;
        check("rdw2_before_rd1", rf.rd1, 32'h1111_1111);
        tick();
        check("rdw2_after_rd1", rf.rd1, 32'h2222_2222);
        check("rdw2_after_rd2", rf.rd2, 32'h2222_2222);

        // Asynchronous reset mid-operation, then a write blocked by reset
        drive(5'd3, 5'd12, 5'd3, 32'ha5a5_a5a5, 1'b1); tick();
        rf.we = 1'b0;
        #1;
        check("async_pre_x3", rf.rd1, 32'ha5a5_a5a5);
        #2 rst_n = 1'b0;
        model_clear();
        #1;
        check("async_x3_cleared", rf.rd1, 32'h0);
        check("async_x12_cleared", rf.rd2, 32'h0);
        drive(5'd3, 5'd3, 5'd3, 32'h1234_5678, 1'b1);
        tick();
        check("reset_write_blocked", rf.rd1, 32'h0);
        rf.we = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        check("post_release_x3", rf.rd1, 32'h0);

        // Dual port and overwrite on x31
        drive(5'd31, 5'd31, 5'd31, 32'h8000_0001, 1'b1); tick();
        drive(5'd31, 5'd31, 5'd31, 32'h7fff_fffe, 1'b1); tick();
        rf.we = 1'b0;
        #1;
        check("overwrite_rd1", rf.rd1, 32'h7fff_fffe);
        check("overwrite_rd2", rf.rd2, 32'h7fff_fffe);

        // Randomized traffic with occasional asynchronous reset pulses
        for (int n = 0; n < 400; n++) begin
            drive(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 3) != 0));
            #1;
            check_ports("rand_pre");
            if ($urandom_range(0, 63) == 0) begin
                #1 rst_n = 1'b0;
                model_clear();
                #1;
                check_ports("rand_in_reset");
                tick();
                #2 rst_n = 1'b1;
            end else begin
                tick();
            end
            check_ports("rand_post");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_br_regfile
`default_nettype wire

// File: doc/br_regfile.md
# br_regfile

Integer register file for the RV32I data path: 32 general-purpose registers of 32 bits with two combinational read ports and one synchronous write port. It sits between instruction decode and the ALU. Decode supplies the rs1/rs2/rd indices, and the write-back stage drives the write data and write enable. Register x0 is hardwired to zero.

## Interface
- XLEN, default 32: register width in bits.
- NREG, default 32: number of registers. Must be a power of two; the address width is log2(NREG) = 5.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- a1  in  5  read-port-1 address (rs1).
- a2  in  5  read-port-2 address (rs2).
- a3  in  5  write address (rd).
- wd3  in  XLEN  write data.
- we  in  1  write enable, active-high.
- rd1  out  XLEN  contents of register a1.
- rd2  out  XLEN  contents of register a2.

## Operation
- Storage is NREG x XLEN. Entry 0 is never stored: x0 always reads 0.
- Write:
  - On the rising edge of clk, if we=1 and a3!=0, then reg[a3] <= wd3.
  - If we=1 and a3=0, the write is silently discarded.
  - If we=0, nothing changes, regardless of a3 and wd3.
- Read:
  - rd1 = (a1==0) ? 0 : reg[a1], purely combinational.
  - rd2 follows the same rule using a2.
  - Both ports are independent; a1==a2 is legal and returns identical data.
- There is no write-to-read bypass. A read of a3 in the same cycle as the write returns the old value. The new value appears on rd1/rd2 right after the rising edge that commits it.
- Reset:
  - While rst_n=0, all registers are cleared to 0 immediately, without waiting for a clock edge.
  - While rst_n=0, rd1 and rd2 read 0 for every address.
  - Writes are blocked while rst_n=0.
  - The first write after release occurs on the first rising edge with rst_n=1 and we=1.
- An X or Z on we or a3 must never corrupt x0.

## Timing
- Read latency: 0 cycles (combinational from a1/a2 and the register state).
- Write latency: 1 edge. Data sampled at edge N is visible on the read ports after edge N.
- Reset assertion is asynchronous. Deassertion is sampled synchronously by the write logic.
- Reset values: every register is 0; rd1=0 and rd2=0 while in reset.
- If rst_n falls in the same cycle as a write, reset wins and the register ends at 0.
- Back-to-back writes to the same address: the last one wins. Writes to different addresses on consecutive edges each commit.

## Structure
- A shared package (rv32i_pkg) holds:
  - XLEN = 32
  - REG_ADDR_W = 5
  - REG_ZERO = 5'd0
  - a reg_addr_t typedef, reused by the decode and write-back stages
- A single module with no sub-module. The storage is an array of flops (not an inferred RAM), because reset must clear every entry.
- Read muxes are combinational. The x0 read mask is implemented on the read side.

## Test plan
- Reset then scan:
  - Stimulus: rst_n=0 then 1; sweep a1 over 0,2,…,30 and a2 over 1,3,…,31.
  - Required: every rd1/rd2 = 0x00000000.
- Basic writes:
  - Stimulus: we=1 with x10←0x00000012, x5←0x0000f00f, x21←0x00000abc, x0←0xffffffff; then we=0 and scan all 32 registers.
  - Required: x5=0x0000f00f, x10=0x00000012, x21=0x00000abc, x0=0, all other registers 0.
- Write enable low:
  - Stimulus: we=0, a3=7, wd3=0xdeadbeef for several edges.
  - Required: x7 stays 0.
- Read-during-write:
  - Stimulus: a1=a2=a3=12, wd3=0x11111111, we=1, then a second write of 0x22222222.
  - Required: before each edge rd1/rd2 show the old value; after each edge they show the new value.
- Asynchronous reset mid-operation:
  - Stimulus: load x3=0xa5a5a5a5; drop rst_n between clock edges.
  - Required: rd1 (a1=3) reads 0 before the next edge.
  - Stimulus: a write attempted while in reset.
  - Required: the write is ignored.
- Dual port and overwrite:
  - Stimulus: x31←0x80000001, then x31←0x7ffffffe; read with a1=a2=31.
  - Required: both ports read 0x7ffffffe.
